// File: rtl/bec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bec_pkg
// Description : Shared definitions for the binary-Edwards-curve ladder
//               sequencer: controller state encoding, default scalar width
//               and the LA status codes reported to the wrapper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bec_pkg;

  // Default scalar width for GF(2^163) operation.
  localparam int KEY_W_DEF = 163;

  // Controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } bec_state_t;

  // Status codes reported to the LA wrapper.
  localparam logic [5:0] LA_STAT_BUSY = 6'b100111;  // ISSUE / WAIT
  localparam logic [5:0] LA_STAT_DONE = 6'b011110;  // DONE

endpackage : bec_pkg
`default_nettype wire

// File: rtl/bec_wdt.sv
`default_nettype none
// ============================================================================
// Module      : bec_wdt
// Description : Watchdog that counts enabled cycles from 0 and flags expiry
//               once the count reaches TIMEOUT-1. The count saturates there
//               until cleared. Shared with the operand-load path.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               clr          - restart count at 0 (priority over en)
//               en           - count this cycle
//               expired      - count has reached TIMEOUT-1 while enabled
// Revision    : 1.0 - initial release
// ============================================================================
module bec_wdt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != C_LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = en && (r_cnt == C_LAST);

endmodule : bec_wdt
`default_nettype wire

// File: rtl/bec_ladder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bec_ladder_ctrl
// Description : Montgomery-ladder sequencer for the BEC scalar multiplier.
//               Captures the scalar on start, walks it MSB-first issuing one
//               ladder step per bit, then requests the projective-to-affine
//               conversion. A watchdog bounds the waits for step_done and
//               fin_done; abort cancels from any state.
// Ports       : clk, rst                 - clock, sync active-high reset
//               start, abort, key_in     - command interface
//               step_req/ack/ki/first/last/done - ladder step handshake
//               fin_req, fin_done        - final conversion handshake
//               iter, busy, done, err    - status
// Revision    : 1.0 - initial release
// ============================================================================
module bec_ladder_ctrl
  import bec_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key_in,
  output logic             step_req,
  input  logic             step_ack,
  output logic             step_ki,
  output logic             step_first,
  output logic             step_last,
  input  logic             step_done,
  output logic             fin_req,
  input  logic             fin_done,
  output logic [CNT_W-1:0] iter,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] C_ITER_LAST = CNT_W'(KEY_W - 1);

  bec_state_t       r_state;
  bec_state_t       w_state_nxt;
  logic [KEY_W-1:0] r_key_sr;
  logic [CNT_W-1:0] r_iter;
  logic             w_last_iter;
  logic             w_wdt_clr;
  logic             w_wdt_en;
  logic             w_wdt_expired;

  assign w_last_iter = (r_iter == C_ITER_LAST);
  assign step_ki     = r_key_sr[KEY_W-1];
  assign iter        = r_iter;

  // Watchdog only runs while waiting on the datapath; any state change
  // (including abort) restarts it so FINAL gets a fresh budget.
  assign w_wdt_en  = (r_state == ST_WAIT) || (r_state == ST_FINAL);
  assign w_wdt_clr = (w_state_nxt != r_state);

  bec_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_wdt_clr),
    .en      (w_wdt_en),
    .expired (w_wdt_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    step_req    = 1'b0;
    step_first  = 1'b0;
    step_last   = 1'b0;
    fin_req     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        step_req   = 1'b1;
        step_first = (r_iter == '0);
        step_last  = w_last_iter;
        if (step_ack) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the expiry cycle still counts as success.
        if (step_done) begin
          w_state_nxt = w_last_iter ? ST_FINAL : ST_ISSUE;
        end else if (w_wdt_expired) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_FINAL: begin
        fin_req = 1'b1;
        if (fin_done) begin
          w_state_nxt = ST_DONE;
        end else if (w_wdt_expired) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        err         = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  // Key shift register and iteration counter. The key shifts on the
  // accepting edge so step_ki already shows the next bit when ISSUE returns.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_key_sr <= '0;
      r_iter   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key_sr <= key_in;
            r_iter   <= '0;
          end
        end
        ST_ISSUE: begin
          if (step_ack) r_key_sr <= r_key_sr << 1;
        end
        ST_WAIT: begin
          if (step_done && !w_last_iter) r_iter <= r_iter + CNT_W'(1);
        end
        ST_DONE, ST_ERR: begin
          r_key_sr <= '0;
          r_iter   <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule : bec_ladder_ctrl
`default_nettype wire
